// File: rtl/instr_mem_pkg.sv
// Shared constants and types for the instruction memory and its runtime loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_mem_pkg;

    localparam int unsigned IMEM_ADDR_W = 16;
    localparam int unsigned IMEM_DATA_W = 17;
    localparam int unsigned IMEM_DEPTH  = 8192;
    localparam logic [7:0]  LOADER_SYNC = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_HI = 4'd1,
        ST_ADDR_LO = 4'd2,
        ST_CNT_HI  = 4'd3,
        ST_CNT_LO  = 4'd4,
        ST_W0      = 4'd5,
        ST_W1      = 4'd6,
        ST_W2      = 4'd7,
        ST_CHK     = 4'd8,
        ST_ERR     = 4'd9
    } loader_state_t;

    // True when [start, start+count) lies inside a memory of 'depth' words.
    // The sum is formed in 17 bits so a large start plus count cannot wrap.
    function automatic logic range_ok(input logic [15:0] start,
                                      input logic [15:0] count,
                                      input int unsigned depth);
        logic [16:0] w_end;
        w_end = {1'b0, start} + {1'b0, count};
        return (w_end <= depth[16:0]);
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and memory write-port output of the instruction loader.
// Latency: n/a (wiring only).
// Backpressure: none; the byte strobe is always accepted by the loader.
interface instr_mem_loader_if #(
    parameter int unsigned ADDR_W = instr_mem_pkg::IMEM_ADDR_W,
    parameter int unsigned DATA_W = instr_mem_pkg::IMEM_DATA_W
);
    logic [7:0]        rx_data;
    logic              rx_vld;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    // Host / serial-link side: drives bytes, observes the loader.
    modport master (
        output rx_data, rx_vld,
        input  we, waddr, wdata, cpu_hold, done, err
    );

    // Loader side: consumes bytes, drives the memory write port and status.
    modport slave (
        input  rx_data, rx_vld,
        output we, waddr, wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/loader_timeout_cnt.sv
// Clearable saturating idle counter; flags expiry once MAX_CNT cycles have elapsed.
// Latency: expiry visible the cycle after the count reaches MAX_CNT (registered count, combinational compare).
// Backpressure: none; clear has priority over increment.
module loader_timeout_cnt #(
    parameter int unsigned MAX_CNT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam int unsigned CNT_W = $clog2(MAX_CNT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max  = (r_cnt == CNT_W'(MAX_CNT));
    assign o_expired = w_at_max;

    // Count idle cycles, holding at the limit instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Assembles 17-bit words from a framed byte stream and writes them into instruction memory at runtime.
// Latency: write pulse 1 clk after the third byte of each word; done 1 clk after the final byte.
// Backpressure: none; every byte strobe is consumed. Optional trailing checksum byte: LOADER_CHKSUM_EN.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = IMEM_ADDR_W,
    parameter int unsigned DATA_W      = IMEM_DATA_W,
    parameter int unsigned MEM_DEPTH   = IMEM_DEPTH,
    parameter logic [7:0]  SYNC_BYTE   = LOADER_SYNC,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input logic               clk,
    input logic               rst,
    instr_mem_loader_if.slave bus
);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [15:0]       r_remain;
    logic [15:0]       w_remain_nxt;
    // Holds the high byte of the address, then of the count.
    logic [7:0]        r_hi;
    logic [7:0]        w_hi_nxt;
    logic              r_b0;
    logic              w_b0_nxt;
    logic [7:0]        r_b1;
    logic [7:0]        w_b1_nxt;

    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_hold;
    logic              w_hold_nxt;

`ifdef LOADER_CHKSUM_EN
    logic [7:0]        r_sum;
    logic [7:0]        w_sum_nxt;
`endif

    logic              w_in_frame;
    logic              w_to_expired;
    logic [15:0]       w_count;
    logic [DATA_W-1:0] w_word;
    logic              w_finish;

    assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_ERR);
    assign w_count    = {r_hi, bus.rx_data};
    assign w_word     = DATA_W'({r_b0, r_b1, bus.rx_data});

    loader_timeout_cnt #(
        .MAX_CNT (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (bus.rx_vld || !w_in_frame),
        .i_inc     (w_in_frame && !bus.rx_vld),
        .o_expired (w_to_expired)
    );

    // Next-state, datapath and output decode for the frame parser.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        w_hi_nxt     = r_hi;
        w_b0_nxt     = r_b0;
        w_b1_nxt     = r_b1;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        w_hold_nxt   = r_hold;
        w_finish     = 1'b0;
`ifdef LOADER_CHKSUM_EN
        w_sum_nxt    = r_sum;
        // Every byte after SYNC up to the last word byte joins the sum.
        if (bus.rx_vld && w_in_frame && (r_state != ST_CHK)) begin
            w_sum_nxt = r_sum + bus.rx_data;
        end
`endif

        if (w_in_frame && w_to_expired) begin
            // A stalled link abandons the frame; the stale byte gap wins over a late byte.
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
        end else if (bus.rx_vld) begin
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        w_state_nxt = ST_ADDR_HI;
                        w_hold_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
`ifdef LOADER_CHKSUM_EN
                        w_sum_nxt   = 8'h00;
`endif
                    end
                end
                ST_ADDR_HI: begin
                    w_hi_nxt    = bus.rx_data;
                    w_state_nxt = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    w_addr_nxt  = ADDR_W'({r_hi, bus.rx_data});
                    w_state_nxt = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    w_hi_nxt    = bus.rx_data;
                    w_state_nxt = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    w_remain_nxt = w_count;
                    if (!range_ok(16'(r_addr), w_count, MEM_DEPTH)) begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end else if (w_count == 16'd0) begin
                        w_finish = 1'b1;
                    end else begin
                        w_state_nxt = ST_W0;
                    end
                end
                ST_W0: begin
                    w_b0_nxt    = bus.rx_data[0];
                    w_state_nxt = ST_W1;
                end
                ST_W1: begin
                    w_b1_nxt    = bus.rx_data;
                    w_state_nxt = ST_W2;
                end
                ST_W2: begin
                    w_we_nxt     = 1'b1;
                    w_waddr_nxt  = r_addr;
                    w_wdata_nxt  = w_word;
                    w_addr_nxt   = r_addr + ADDR_W'(1);
                    w_remain_nxt = r_remain - 16'd1;
                    if (r_remain == 16'd1) begin
                        w_finish = 1'b1;
                    end else begin
                        w_state_nxt = ST_W0;
                    end
                end
`ifdef LOADER_CHKSUM_EN
                ST_CHK: begin
                    if (bus.rx_data == r_sum) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_hold_nxt  = 1'b0;
                    end else begin
                        // Words already written stay written; only the flag reports the corruption.
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        if (w_finish) begin
`ifdef LOADER_CHKSUM_EN
            w_state_nxt = ST_CHK;
`else
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_hi     <= '0;
            r_b0     <= 1'b0;
            r_b1     <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_addr   <= w_addr_nxt;
            r_remain <= w_remain_nxt;
            r_hi     <= w_hi_nxt;
            r_b0     <= w_b0_nxt;
            r_b1     <= w_b1_nxt;
            r_we     <= w_we_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

`ifdef LOADER_CHKSUM_EN
    // Running modular checksum of the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= 8'h00;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    // Pulses are masked while rst is high so a write registered just before
    // reset never reaches the memory.
    assign bus.we       = r_we & ~rst;
    assign bus.done     = r_done & ~rst;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign bus.cpu_hold = r_hold;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: directed frames, expected writes queued, monitor compares.
// Latency: checks sampled on the falling edge.
// Backpressure: none exercised; the loader never stalls the byte stream.
module tb_instr_mem_loader;
    import instr_mem_pkg::*;

    localparam int unsigned TO = 100;

    typedef struct packed {
        logic [15:0] addr;
        logic [16:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_vec = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    int         done_base;
    wr_t        exp_q[$];
    logic [7:0] fr[$];

    instr_mem_loader_if bus ();

    instr_mem_loader #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_vld  = 1'b0;
    endtask

    // Sends the frame in fr back-to-back; chk is the hand-computed trailing byte.
    task automatic send_frame(input logic [7:0] chk);
        foreach (fr[i]) send_byte(fr[i]);
`ifdef LOADER_CHKSUM_EN
        send_byte(chk);
`else
        if (chk == 8'h00) begin end
`endif
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [16:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.we) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_we: got addr %0h data %0h, required no write", bus.waddr, bus.wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("we_addr", 32'(bus.waddr), 32'(e.addr));
                check("we_data", 32'(bus.wdata), 32'(e.data));
            end
        end
        if (bus.done) done_cnt++;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        idle(4);

        // Reset state
        check("rst_we",    32'(bus.we),       0);
        check("rst_waddr", 32'(bus.waddr),    0);
        check("rst_wdata", 32'(bus.wdata),    0);
        check("rst_hold",  32'(bus.cpu_hold), 0);
        check("rst_done",  32'(bus.done),     0);
        check("rst_err",   32'(bus.err),      0);
        rst = 1'b0;
        idle(2);

        // Basic two-word frame
        done_base = done_cnt;
        push_wr(16'h0010, 17'h11234);
        push_wr(16'h0011, 17'h0ABCD);
        send_byte(8'hA5);
        check("basic_hold_on", 32'(bus.cpu_hold), 1);
        fr = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD};
        send_frame(8'hD1);
        idle(3);
        check("basic_done",     32'(done_cnt - done_base), 1);
        check("basic_hold_off", 32'(bus.cpu_hold), 0);
        check("basic_err",      32'(bus.err), 0);
        check("basic_wq",       32'(exp_q.size()), 0);
        check("basic_waddr_hold", 32'(bus.waddr), 32'h0011);
        check("basic_wdata_hold", 32'(bus.wdata), 32'h0ABCD);

`ifdef LOADER_CHKSUM_EN
        // Bad checksum: writes still land, error is sticky, no done
        done_base = done_cnt;
        push_wr(16'h0010, 17'h11234);
        push_wr(16'h0011, 17'h0ABCD);
        fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD};
        send_frame(8'h2E);
        idle(3);
        check("badchk_err",  32'(bus.err), 1);
        check("badchk_hold", 32'(bus.cpu_hold), 1);
        check("badchk_done", 32'(done_cnt - done_base), 0);
        check("badchk_wq",   32'(exp_q.size()), 0);
        done_base = done_cnt;
        push_wr(16'h0010, 17'h11234);
        push_wr(16'h0011, 17'h0ABCD);
        send_frame(8'hD1);
        idle(3);
        check("recover_err",  32'(bus.err), 0);
        check("recover_done", 32'(done_cnt - done_base), 1);
        check("recover_hold", 32'(bus.cpu_hold), 0);
`endif

        // Out of range: start 0x1FFF, count 2 -> error, no writes
        fr = '{8'hA5, 8'h1F, 8'hFF, 8'h00, 8'h02};
        foreach (fr[i]) send_byte(fr[i]);
        idle(3);
        check("oob_err",  32'(bus.err), 1);
        check("oob_hold", 32'(bus.cpu_hold), 1);

        // Last legal address, count 1: restarts from the error state
        done_base = done_cnt;
        push_wr(16'h1FFF, 17'h1FEDC);
        fr = '{8'hA5, 8'h1F, 8'hFF, 8'h00, 8'h01, 8'h01, 8'hFE, 8'hDC};
        send_frame(8'hFA);
        idle(3);
        check("edge_err",  32'(bus.err), 0);
        check("edge_done", 32'(done_cnt - done_base), 1);
        check("edge_hold", 32'(bus.cpu_hold), 0);
        check("edge_wq",   32'(exp_q.size()), 0);

        // Timeout inside the header
        fr = '{8'hA5, 8'h00, 8'h00};
        foreach (fr[i]) send_byte(fr[i]);
        idle(TO - 3);
        check("to_early_err", 32'(bus.err), 0);
        idle(6);
        check("to_err",  32'(bus.err), 1);
        check("to_hold", 32'(bus.cpu_hold), 1);

        // Reset in the cycle after the last word byte: write is dropped
        fr = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        foreach (fr[i]) send_byte(fr[i]);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        #1;
        check("mid_rst_we",    32'(bus.we),       0);
        check("mid_rst_waddr", 32'(bus.waddr),    0);
        check("mid_rst_wdata", 32'(bus.wdata),    0);
        check("mid_rst_hold",  32'(bus.cpu_hold), 0);
        check("mid_rst_err",   32'(bus.err),      0);
        check("mid_rst_state", 32'(dut.r_state),  32'(ST_IDLE));
        idle(2);

        // Empty frame then back-to-back frame carrying 0xA5 data bytes
        done_base = done_cnt;
        push_wr(16'h0041, 17'h0A5A5);
        push_wr(16'h0042, 17'h1A500);
        fr = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00};
        send_frame(8'h40);
        fr = '{8'hA5, 8'h00, 8'h41, 8'h00, 8'h02, 8'h00, 8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h00};
        send_frame(8'h33);
        idle(3);
        check("b2b_done", 32'(done_cnt - done_base), 2);
        check("b2b_hold", 32'(bus.cpu_hold), 0);
        check("b2b_err",  32'(bus.err), 0);
        check("b2b_wq",   32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
